// File: rtl/register_writeback_pkg.sv
// Shared constants, helpers and types for the register writeback front end.
// Holds default widths, the ceil-log2 helper and the write-port source enum.
package register_writeback_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_L   = 32;
    localparam int DEF_QUEUE_D  = 4;
    localparam int DEF_STARVE_L = 3;

    function automatic int util_math_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_ADDR_W  = util_math_log2(DEF_ADDR_L);
    localparam int DEF_ENTRY_W = DEF_ADDR_W + DEF_DATA_W;

    typedef enum logic [1:0] {
        ARB_NONE  = 2'd0,
        ARB_PIPE  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_src_e;

endpackage

// File: rtl/register_writeback_if.sv
// Bundle of writeback, long-unit, decode and register-file signals.
// The master side is the pipeline/decode environment; the slave side is the writeback block.
interface register_writeback_if #(
    parameter int ADDR_W = register_writeback_pkg::DEF_ADDR_W,
    parameter int DATA_W = register_writeback_pkg::DEF_DATA_W
);
    logic              pipe_en;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_data;
    logic              long_valid;
    logic              long_ready;
    logic [ADDR_W-1:0] long_addr;
    logic [DATA_W-1:0] long_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] rd2_addr;
    logic              rd1_pending;
    logic              rd2_pending;
    logic              stall_req;
    logic              waw_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output pipe_en, pipe_addr, pipe_data,
        output long_valid, long_addr, long_data,
        output issue_en, issue_addr, rd1_addr, rd2_addr,
        input  long_ready, rd1_pending, rd2_pending, stall_req, waw_err,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pipe_en, pipe_addr, pipe_data,
        input  long_valid, long_addr, long_data,
        input  issue_en, issue_addr, rd1_addr, rd2_addr,
        output long_ready, rd1_pending, rd2_pending, stall_req, waw_err,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/register_writeback_queue.sv
// Small synchronous FIFO for long-latency results with a combinational head peek,
// so the head can be driven onto the write port in the same cycle it is popped.
module register_writeback_queue
    import register_writeback_pkg::*;
#(
    parameter int  WIDTH = DEF_ENTRY_W,
    parameter int  DEPTH = DEF_QUEUE_D,
    localparam int PTR_W = util_math_log2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_head];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/register_writeback.sv
// Merges pipeline writebacks and queued long-latency results onto the single
// register-file write port, tracking pending destinations for decode hazard stalls.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  ADDR_L   = DEF_ADDR_L,
    parameter int  QUEUE_D  = DEF_QUEUE_D,
    parameter int  STARVE_L = DEF_STARVE_L,
    localparam int ADDR_W   = util_math_log2(ADDR_L)
) (
    input logic                  i_clk,
    input logic                  i_srst,
    register_writeback_if.slave  bus
);

    localparam int ENTRY_W  = ADDR_W + DATA_W;
    localparam int CNT_W    = util_math_log2(QUEUE_D) + 1;
    localparam int STARVE_W = util_math_log2(STARVE_L + 1);

    logic [ENTRY_W-1:0]  w_head;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_q_full;
    logic                w_q_empty;
    logic [CNT_W-1:0]    w_q_count;
    logic                w_pipe_win;
    logic                w_drain;
    logic                w_push;
    logic                w_long_ready;
    logic                w_issue;
    logic                w_waw_hit;
    arb_src_e            w_src;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [ADDR_L-1:0]   w_pending_next;
    logic [ADDR_L-1:0]   r_pending;
    logic [STARVE_W-1:0] r_starve;
    logic                r_waw_err;

    assign w_head_addr  = w_head[ENTRY_W-1 -: ADDR_W];
    assign w_head_data  = w_head[DATA_W-1:0];
    assign w_pipe_win   = bus.pipe_en && (bus.pipe_addr != '0);
    assign w_long_ready = !i_srst && !w_q_full;
    // Results for r0 are acknowledged but never enter the queue.
    assign w_push       = bus.long_valid && w_long_ready && (bus.long_addr != '0);
    assign w_drain      = (w_src == ARB_DRAIN);
    assign w_issue      = bus.issue_en && (bus.issue_addr != '0);

    register_writeback_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_D)
    ) u_queue (
        .i_clk       (i_clk),
        .i_srst      (i_srst),
        .i_push      (w_push),
        .i_push_data ({bus.long_addr, bus.long_data}),
        .i_pop       (w_drain),
        .o_head      (w_head),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty),
        .o_count     (w_q_count)
    );

    always_comb begin
        w_src = ARB_NONE;
        if (!i_srst) begin
            if (w_pipe_win) begin
                w_src = ARB_PIPE;
            end else if (!w_q_empty) begin
                w_src = ARB_DRAIN;
            end
        end
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        case (w_src)
            ARB_PIPE: begin
                w_wr_en   = 1'b1;
                w_wr_addr = bus.pipe_addr;
                w_wr_data = bus.pipe_data;
            end
            ARB_DRAIN: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_head_addr;
                w_wr_data = w_head_data;
            end
            default: ;
        endcase
    end

    // A fresh reservation outranks the clear from a same-cycle drain of that register.
    assign w_pending_next[0] = 1'b0;
    genvar gi;
    for (gi = 1; gi < ADDR_L; gi++) begin : g_pending
        assign w_pending_next[gi] =
            (w_issue && (bus.issue_addr == ADDR_W'(gi))) ? 1'b1 :
            (w_drain && (w_head_addr == ADDR_W'(gi)))    ? 1'b0 :
            r_pending[gi];
    end

    // Re-reserving a register whose result is being written this cycle is not a hazard.
    assign w_waw_hit = w_issue && r_pending[bus.issue_addr] &&
                       !(w_drain && (w_head_addr == bus.issue_addr));

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_pending <= '0;
            r_waw_err <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_waw_err <= r_waw_err | w_waw_hit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_starve <= '0;
        end else if (w_q_empty || w_drain) begin
            r_starve <= '0;
        end else if (r_starve != STARVE_W'(STARVE_L)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign bus.long_ready  = w_long_ready;
    assign bus.stall_req   = (r_starve == STARVE_W'(STARVE_L)) || (w_q_count == CNT_W'(QUEUE_D));
    assign bus.waw_err     = r_waw_err;
    assign bus.wr_en       = w_wr_en;
    assign bus.wr_addr     = w_wr_addr;
    assign bus.wr_data     = w_wr_data;
    // The register file forwards the draining value, so that operand is already available.
    assign bus.rd1_pending = r_pending[bus.rd1_addr] && !(w_drain && (w_head_addr == bus.rd1_addr));
    assign bus.rd2_pending = r_pending[bus.rd2_addr] && !(w_drain && (w_head_addr == bus.rd2_addr));

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback: a queue/array reference model checked every
// cycle, plus hand-computed literal expectations along the test-plan scenarios.
module tb_register_writeback;

    logic clk;
    logic srst;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    register_writeback_if bus ();

    register_writeback u_dut (
        .i_clk  (clk),
        .i_srst (srst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          mpend[32];
    int          mstarve;
    bit          mwaw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of results, an array of pending flags and a starve count.
    always @(posedge clk) begin
        bit pw, dr, acc;
        if (srst) begin
            mq.delete();
            for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
            mstarve = 0;
            mwaw    = 1'b0;
        end else begin
            pw  = bus.pipe_en && (bus.pipe_addr != 0);
            dr  = !pw && (mq.size() > 0);
            acc = bus.long_valid && (mq.size() < 4) && (bus.long_addr != 0);
            if (bus.issue_en && bus.issue_addr != 0 && mpend[bus.issue_addr] &&
                !(dr && mq[0].a == bus.issue_addr))
                mwaw = 1'b1;
            if (dr) mpend[mq[0].a] = 1'b0;
            if (bus.issue_en && bus.issue_addr != 0) mpend[bus.issue_addr] = 1'b1;
            if (mq.size() == 0 || dr) mstarve = 0;
            else if (mstarve < 3) mstarve = mstarve + 1;
            if (dr) void'(mq.pop_front());
            if (acc) mq.push_back('{a: bus.long_addr, d: bus.long_data});
        end
    end

    always @(negedge clk) begin
        bit pw, dr;
        logic e_en;
        logic [4:0] e_a;
        logic [31:0] e_d;
        if (chk_en) begin
            pw  = bus.pipe_en && (bus.pipe_addr != 0);
            dr  = !srst && !pw && (mq.size() > 0);
            e_en = 1'b0; e_a = '0; e_d = '0;
            if (!srst && pw) begin
                e_en = 1'b1; e_a = bus.pipe_addr; e_d = bus.pipe_data;
            end else if (dr) begin
                e_en = 1'b1; e_a = mq[0].a; e_d = mq[0].d;
            end
            chk("m_wr_en", 32'(bus.wr_en), 32'(e_en));
            chk("m_wr_addr", 32'(bus.wr_addr), 32'(e_a));
            chk("m_wr_data", bus.wr_data, e_d);
            chk("m_long_ready", 32'(bus.long_ready), 32'(!srst && mq.size() < 4));
            chk("m_stall_req", 32'(bus.stall_req), 32'(mstarve == 3 || mq.size() == 4));
            chk("m_waw_err", 32'(bus.waw_err), 32'(mwaw));
            chk("m_rd1_pending", 32'(bus.rd1_pending),
                32'(mpend[bus.rd1_addr] && !(dr && mq[0].a == bus.rd1_addr)));
            chk("m_rd2_pending", 32'(bus.rd2_pending),
                32'(mpend[bus.rd2_addr] && !(dr && mq[0].a == bus.rd2_addr)));
            if (bus.wr_en)
                $display("[TB] t=%0t write r%0d = %08h", $time, bus.wr_addr, bus.wr_data);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        srst    = 1'b1;
        bus.pipe_en = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
        bus.long_valid = 0; bus.long_addr = 0; bus.long_data = 0;
        bus.issue_en = 0; bus.issue_addr = 0;
        bus.rd1_addr = 0; bus.rd2_addr = 0;
        adv();
        chk_en = 1'b1;
        adv();
        srst = 1'b0;

        // Reset state
        settle();
        chk("rst_long_ready", 32'(bus.long_ready), 32'd1);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        chk("rst_waw", 32'(bus.waw_err), 32'd0);
        adv();

        // Pipe only
        bus.pipe_en = 1; bus.pipe_addr = 5; bus.pipe_data = 32'hDEAD;
        settle();
        chk("pipe_wr_en", 32'(bus.wr_en), 32'd1);
        chk("pipe_wr_addr", 32'(bus.wr_addr), 32'd5);
        chk("pipe_wr_data", bus.wr_data, 32'hDEAD);
        adv();
        bus.pipe_addr = 0;
        settle();
        chk("pipe_r0_wr_en", 32'(bus.wr_en), 32'd0);
        adv();
        bus.pipe_en = 0;

        // Long path
        bus.issue_en = 1; bus.issue_addr = 8;
        adv();
        bus.issue_en = 0; bus.rd1_addr = 8;
        settle();
        chk("long_rd1_pend_a", 32'(bus.rd1_pending), 32'd1);
        adv();
        bus.long_valid = 1; bus.long_addr = 8; bus.long_data = 32'h1234;
        settle();
        chk("long_rd1_pend_b", 32'(bus.rd1_pending), 32'd1);
        chk("long_accept_wr_en", 32'(bus.wr_en), 32'd0);
        adv();
        bus.long_valid = 0;
        settle();
        chk("long_drain_wr_en", 32'(bus.wr_en), 32'd1);
        chk("long_drain_addr", 32'(bus.wr_addr), 32'd8);
        chk("long_drain_data", bus.wr_data, 32'h1234);
        chk("long_drain_rd1_pend", 32'(bus.rd1_pending), 32'd0);
        adv();
        settle();
        chk("long_after_rd1_pend", 32'(bus.rd1_pending), 32'd0);
        adv();

        // Contention: r9 queued behind a busy pipe
        bus.issue_en = 1; bus.issue_addr = 9;
        adv();
        bus.issue_en = 0;
        bus.pipe_en = 1; bus.pipe_addr = 1; bus.pipe_data = 32'h11;
        bus.long_valid = 1; bus.long_addr = 9; bus.long_data = 32'h99;
        adv();
        bus.long_valid = 0;
        for (int i = 0; i < 3; i++) begin
            bus.pipe_data = 32'h20 + 32'(i);
            settle();
            chk("cont_pipe_wins", 32'(bus.wr_addr), 32'd1);
            chk("cont_no_stall", 32'(bus.stall_req), 32'd0);
            adv();
        end
        settle();
        chk("cont_stall", 32'(bus.stall_req), 32'd1);
        adv();
        bus.pipe_en = 0;
        settle();
        chk("cont_drain_addr", 32'(bus.wr_addr), 32'd9);
        chk("cont_drain_data", bus.wr_data, 32'h99);
        adv();
        settle();
        chk("cont_stall_clear", 32'(bus.stall_req), 32'd0);
        adv();

        // Full queue
        bus.pipe_en = 1; bus.pipe_addr = 2; bus.pipe_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            bus.long_valid = 1; bus.long_addr = 5'(10 + i); bus.long_data = 32'hA0 + 32'(i);
            adv();
        end
        bus.long_addr = 14; bus.long_data = 32'hEE;
        settle();
        chk("full_long_ready", 32'(bus.long_ready), 32'd0);
        chk("full_stall", 32'(bus.stall_req), 32'd1);
        adv();
        bus.long_valid = 0; bus.pipe_en = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("full_drain_addr", 32'(bus.wr_addr), 32'(10 + i));
            chk("full_drain_data", bus.wr_data, 32'hA0 + 32'(i));
            adv();
        end
        settle();
        chk("full_empty_wr_en", 32'(bus.wr_en), 32'd0);
        adv();

        // Hazards
        bus.issue_en = 1; bus.issue_addr = 3;
        adv();
        adv();
        bus.issue_en = 0;
        settle();
        chk("waw_set", 32'(bus.waw_err), 32'd1);
        adv();
        adv();
        settle();
        chk("waw_sticky", 32'(bus.waw_err), 32'd1);
        bus.issue_en = 1; bus.issue_addr = 4;
        adv();
        bus.issue_en = 0;
        bus.long_valid = 1; bus.long_addr = 4; bus.long_data = 32'h44;
        adv();
        bus.long_valid = 0;
        bus.issue_en = 1; bus.issue_addr = 4;
        settle();
        chk("reissue_drain_addr", 32'(bus.wr_addr), 32'd4);
        adv();
        bus.issue_en = 0; bus.rd2_addr = 4;
        settle();
        chk("reissue_pending", 32'(bus.rd2_pending), 32'd1);
        adv();

        // Reset mid-operation
        bus.issue_en = 1; bus.issue_addr = 6;
        adv();
        bus.issue_en = 0;
        bus.pipe_en = 1; bus.pipe_addr = 1; bus.pipe_data = 32'h55;
        bus.long_valid = 1; bus.long_addr = 20; bus.long_data = 32'h2020;
        adv();
        bus.long_addr = 21; bus.long_data = 32'h2121;
        adv();
        bus.long_valid = 0; bus.rd1_addr = 6;
        settle();
        chk("pre_rst_rd1_pend", 32'(bus.rd1_pending), 32'd1);
        adv();
        srst = 1;
        settle();
        chk("in_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("in_rst_long_ready", 32'(bus.long_ready), 32'd0);
        adv();
        srst = 0; bus.pipe_en = 0;
        settle();
        chk("post_rst_long_ready", 32'(bus.long_ready), 32'd1);
        chk("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("post_rst_rd1_pend", 32'(bus.rd1_pending), 32'd0);
        chk("post_rst_rd2_pend", 32'(bus.rd2_pending), 32'd0);
        chk("post_rst_waw", 32'(bus.waw_err), 32'd0);
        chk("post_rst_stall", 32'(bus.stall_req), 32'd0);
        adv();
        adv();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
